// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared encodings for the CPU phase sequencer: FSM states and opcode constants.
package cpu_phase_sequencer_pkg;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC1 = 3'd1,
    S_EXEC2 = 3'd2,
    S_EXEC3 = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDN = 4'h9;
  localparam logic [3:0] OP_RET = 4'hF;
  localparam logic [3:0] OP_SSS = 4'hA;
  localparam logic [7:0] OP_STP = 8'hA0;

endpackage

// File: rtl/cpu_phase_sequencer.sv
// Instruction phase sequencer: FETCH/EXEC1..3 strobes, instruction register,
// previous-major-opcode register and latched condition flags.
module cpu_phase_sequencer
  import cpu_phase_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 8,
  parameter int CMP_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic [DATA_W-1:0]         ram_q,
  input  logic                      flag_load,
  input  logic                      alu_eq,
  input  logic                      alu_mi,
  input  logic [CMP_W-1:0]          cmp_in,
  output logic                      FETCH,
  output logic                      EXEC1,
  output logic                      EXEC2,
  output logic                      EXEC3,
  output logic                      HALTED,
  output logic [OPC_W-1:0]          IR_opcode,
  output logic [DATA_W-OPC_W-1:0]   IR_operand,
  output logic [3:0]                IR_oldopcode,
  output logic                      EQ,
  output logic                      MI,
  output logic [CMP_W-1:0]          CMPFlag,
  output logic                      instr_done
);

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   ir;
  logic                ir_load;
  logic                old_load;
  logic [3:0]          major;
  logic                is_ldn, is_ret, is_stp;

  assign IR_opcode  = ir[DATA_W-1 -: OPC_W];
  assign IR_operand = ir[DATA_W-OPC_W-1:0];
  assign major      = IR_opcode[OPC_W-1 -: 4];
  assign is_ldn     = (major == OP_LDN);
  assign is_ret     = (major == OP_RET);
  // STP is the SSS group with a zero sub-op; other SSS sub-ops run as plain 2-cycle ops.
  assign is_stp     = (major == OP_STP[7:4]) && (IR_opcode[OPC_W-5:0] == '0);

  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    old_load  = 1'b0;
    case (state)
      S_FETCH: if (!stall) begin
        state_nxt = S_EXEC1;
        ir_load   = 1'b1;
      end
      S_EXEC1: if (!stall) begin
        old_load = 1'b1;
        if (is_ldn || is_ret) state_nxt = S_EXEC2;
        else if (is_stp)      state_nxt = S_HALT;
        else                  state_nxt = S_FETCH;
      end
      S_EXEC2: if (!stall) begin
        if (is_ldn) begin
          state_nxt = S_EXEC3;
          ir_load   = 1'b1;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_EXEC3: if (!stall) state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir           <= '0;
      IR_oldopcode <= '0;
      EQ           <= 1'b0;
      MI           <= 1'b0;
      CMPFlag      <= '0;
    end else begin
      if (ir_load)  ir           <= ram_q;
      if (old_load) IR_oldopcode <= major;
      if (flag_load && !stall) begin
        EQ      <= alu_eq;
        MI      <= alu_mi;
        CMPFlag <= cmp_in;
      end
    end
  end

  always_comb begin
    FETCH      = (state == S_FETCH);
    EXEC1      = (state == S_EXEC1);
    EXEC2      = (state == S_EXEC2);
    EXEC3      = (state == S_EXEC3);
    HALTED     = (state == S_HALT);
    instr_done = 1'b0;
    if (!stall) begin
      case (state)
        S_EXEC1: instr_done = !(is_ldn || is_ret);
        S_EXEC2: instr_done = is_ret;
        S_EXEC3: instr_done = 1'b1;
        default: instr_done = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Bench for cpu_phase_sequencer: directed scenarios plus random instruction
// streams, checked each cycle against an instruction-length reference model.
module tb_cpu_phase_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [15:0] ram_q;
  logic        flag_load;
  logic        alu_eq;
  logic        alu_mi;
  logic [3:0]  cmp_in;
  logic        FETCH, EXEC1, EXEC2, EXEC3, HALTED;
  logic [7:0]  IR_opcode;
  logic [7:0]  IR_operand;
  logic [3:0]  IR_oldopcode;
  logic        EQ, MI;
  logic [3:0]  CMPFlag;
  logic        instr_done;

  cpu_phase_sequencer #(.DATA_W(16), .OPC_W(8), .CMP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ram_q(ram_q),
    .flag_load(flag_load), .alu_eq(alu_eq), .alu_mi(alu_mi), .cmp_in(cmp_in),
    .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2), .EXEC3(EXEC3), .HALTED(HALTED),
    .IR_opcode(IR_opcode), .IR_operand(IR_operand), .IR_oldopcode(IR_oldopcode),
    .EQ(EQ), .MI(MI), .CMPFlag(CMPFlag), .instr_done(instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: position within the current instruction and its length.
  int          m_k;
  int          m_len;
  logic [15:0] m_ir;
  logic [3:0]  m_old;
  logic        m_eq, m_mi;
  logic [3:0]  m_cmp;
  logic        m_halt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int instr_len(input logic [7:0] op);
    if (op[7:4] == 4'h9) return 4;
    if (op[7:4] == 4'hF) return 3;
    return 2;
  endfunction

  task automatic model_reset();
    m_k = 0; m_len = 2; m_ir = '0; m_old = '0;
    m_eq = 1'b0; m_mi = 1'b0; m_cmp = '0; m_halt = 1'b0;
  endtask

  task automatic model_edge();
    if (!m_halt && !stall) begin
      if (m_k == 0) begin
        m_ir  = ram_q;
        m_len = instr_len(ram_q[15:8]);
        m_k   = 1;
      end else if (m_k == 1) begin
        m_old = m_ir[15:12];
        if (m_ir[15:8] == 8'hA0) m_halt = 1'b1;
        else m_k = (m_len > 2) ? 2 : 0;
      end else if (m_k == 2) begin
        if (m_len == 4) begin
          m_ir = ram_q;
          m_k  = 3;
        end else begin
          m_k = 0;
        end
      end else begin
        m_k = 0;
      end
    end
    if (flag_load && !stall) begin
      m_eq = alu_eq; m_mi = alu_mi; m_cmp = cmp_in;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [4:0] exp_ph;
    logic       exp_done;
    exp_ph   = m_halt ? 5'b00001 : (5'b10000 >> m_k);
    exp_done = !m_halt && !stall && (m_k != 0) && (m_k == m_len - 1);
    check({tag, ".phase"}, {27'd0, FETCH, EXEC1, EXEC2, EXEC3, HALTED}, {27'd0, exp_ph});
    check({tag, ".ir"},    {16'd0, IR_opcode, IR_operand}, {16'd0, m_ir});
    check({tag, ".old"},   {28'd0, IR_oldopcode}, {28'd0, m_old});
    check({tag, ".flags"}, {26'd0, EQ, MI, CMPFlag}, {26'd0, m_eq, m_mi, m_cmp});
    check({tag, ".done"},  {31'd0, instr_done}, {31'd0, exp_done});
  endtask

  // One clock: drive inputs, check mid-cycle, advance model on the edge.
  task automatic cycle(input string tag, input logic st, input logic [15:0] rq,
                       input logic fl, input logic [3:0] cmp);
    stall = st; ram_q = rq; flag_load = fl;
    alu_eq = cmp[0]; alu_mi = cmp[3]; cmp_in = cmp;
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    stall = 1'b0; flag_load = 1'b0;
    check_outputs(tag);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [7:0] op;
    int         hcount;
    rst_n = 1'b0; stall = 1'b0; ram_q = '0; flag_load = 1'b0;
    alu_eq = 1'b0; alu_mi = 1'b0; cmp_in = '0;
    model_reset();
    #12;
    check_outputs("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;

    // ADD
    cycle("add.f",  1'b0, 16'h2005, 1'b0, 4'h0);
    cycle("add.e1", 1'b0, 16'h0000, 1'b0, 4'h0);
    check("add.opc", {24'd0, IR_opcode}, 32'h20);
    check("add.opr", {24'd0, IR_operand}, 32'h05);
    // LDN with indirect word, flags loaded mid-way
    cycle("ldn.f",  1'b0, 16'h9010, 1'b0, 4'h0);
    cycle("ldn.e1", 1'b0, 16'h0000, 1'b1, 4'b1001);
    cycle("ldn.e2", 1'b0, 16'h0033, 1'b0, 4'h0);
    check("ldn.e3opc", {24'd0, IR_opcode}, 32'h00);
    cycle("ldn.e3", 1'b0, 16'h0000, 1'b0, 4'h0);
    // RET
    cycle("ret.f",  1'b0, 16'hF000, 1'b0, 4'h0);
    cycle("ret.e1", 1'b0, 16'h0000, 1'b0, 4'h0);
    check("ret.old", {28'd0, IR_oldopcode}, 32'hF);
    cycle("ret.e2", 1'b0, 16'h0000, 1'b0, 4'h0);
    // Undefined SSS sub-op is a plain 2-cycle instruction
    cycle("sss.f",  1'b0, 16'hA300, 1'b0, 4'h0);
    cycle("sss.e1", 1'b0, 16'h0000, 1'b0, 4'h0);
    // LDN stalled in EXEC1 with flag_load asserted (must not latch)
    cycle("stl.f",  1'b0, 16'h9022, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) cycle("stl.hold", 1'b1, 16'hFFFF, 1'b1, 4'b1111);
    cycle("stl.e1", 1'b0, 16'h0000, 1'b0, 4'h0);
    cycle("stl.e2", 1'b0, 16'h0044, 1'b0, 4'h0);
    cycle("stl.e3", 1'b0, 16'h0000, 1'b0, 4'h0);
    // STP then 20 halted cycles with stall toggling
    cycle("stp.f",  1'b0, 16'hA000, 1'b0, 4'h0);
    cycle("stp.e1", 1'b0, 16'h0000, 1'b0, 4'h0);
    for (int i = 0; i < 20; i++) cycle("halt", logic'(i % 2), 16'h2001, 1'b0, 4'h0);
    check("halt.st", {31'd0, HALTED}, 32'd1);
    reset_pulse("stp.rst");
    cycle("post.f", 1'b0, 16'h3007, 1'b0, 4'h0);
    cycle("post.e1", 1'b0, 16'h0000, 1'b0, 4'h0);
    // Async reset in the middle of EXEC2, then flag load right after release
    cycle("mid.f",  1'b0, 16'h9055, 1'b1, 4'b1011);
    cycle("mid.e1", 1'b0, 16'h0000, 1'b0, 4'h0);
    reset_pulse("mid.rst");
    cycle("mid.fl", 1'b0, 16'h1000, 1'b1, 4'b0110);
    check("mid.cmp", {28'd0, CMPFlag}, 32'b0110);

    // Random instruction stream
    hcount = 0;
    for (int n = 0; n < 600; n++) begin
      op = 8'($urandom);
      case ($urandom_range(0, 9))
        0, 1: op[7:4] = 4'h9;
        2, 3: op[7:4] = 4'hF;
        4:    op = ($urandom_range(0, 3) == 0) ? 8'hA0 : {4'hA, 4'($urandom_range(1, 15))};
        default: ;
      endcase
      cycle("rnd", ($urandom_range(0, 4) == 0), {op, 8'($urandom)},
            ($urandom_range(0, 2) == 0), 4'($urandom));
      hcount = m_halt ? hcount + 1 : 0;
      if (hcount > 3) begin
        reset_pulse("rnd.rst");
        hcount = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
